// File: rtl/uart_bus_responder.sv
// Memory-mapped UART responder: two RX operand bytes, one TX byte, CON/irq.
// Define UART_PARITY_EN for 8E1 framing (even parity bit on TX and RX).
`timescale 1ns/1ps
module uart_bus_responder #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_MAX = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_e;

  logic [29:0] off;
  logic        in_win, we_txd, we_con;
  logic        unused;

  assign off    = addr[31:2] - BASE_ADDR[31:2];
  assign in_win = (off[29:2] == 28'd0);
  assign we_txd = mem_write & in_win & (off[1:0] == 2'd2);
  assign we_con = mem_write & in_win & (off[1:0] == 2'd3);
  assign unused = ^{addr[1:0], wdata[31:8], wdata[2]};

  logic [7:0] op1_q, op1_d, op2_q, op2_d;
  logic       ready_q, ready_d, irqen_q, irqen_d;
  logic       err_q, err_d, ptr_q, ptr_d, irq_q;
  logic       tx_busy;

  always_comb begin
    rdata = '0;
    if (mem_read && in_win) begin
      unique case (off[1:0])
        2'd0: rdata = {24'b0, op1_q};
        2'd1: rdata = {24'b0, op2_q};
        2'd2: rdata = '0;
        2'd3: rdata = {28'b0, err_q, tx_busy,
                       irqen_q, ready_q};
      endcase
    end
  end

  // RX: 2-flop synchroniser plus one more stage for edge detect
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  state_e          rs_q, rs_d;
  logic [CW-1:0]   rcnt_q, rcnt_d;
  logic [2:0]      rbit_q, rbit_d;
  logic [7:0]      rsh_q, rsh_d;
  logic            rpar_q, rpar_d;
  logic            rx_done, rx_bad;

  always_comb begin
    rs_d    = rs_q;
    rcnt_d  = rcnt_q;
    rbit_d  = rbit_q;
    rsh_d   = rsh_q;
    rpar_d  = rpar_q;
    rx_done = 1'b0;
    rx_bad  = 1'b0;
    unique case (rs_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rs_d   = S_START;
          rcnt_d = HALF_MAX;
          rpar_d = 1'b0;
        end
      end
      S_START: begin
        if (rcnt_q == '0) begin
          if (rx_s2_q) begin
            rs_d = S_IDLE;
          end else begin
            rs_d   = S_DATA;
            rcnt_d = BIT_MAX;
            rbit_d = 3'd0;
          end
        end else begin
          rcnt_d = rcnt_q - ONE;
        end
      end
      S_DATA: begin
        if (rcnt_q == '0) begin
          rsh_d  = {rx_s2_q, rsh_q[7:1]};
          rcnt_d = BIT_MAX;
          if (rbit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            rs_d = S_PAR;
`else
            rs_d = S_STOP;
`endif
          end else begin
            rbit_d = rbit_q + 3'd1;
          end
        end else begin
          rcnt_d = rcnt_q - ONE;
        end
      end
      S_PAR: begin
        if (rcnt_q == '0) begin
          rpar_d = rx_s2_q ^ (^rsh_q);
          rs_d   = S_STOP;
          rcnt_d = BIT_MAX;
        end else begin
          rcnt_d = rcnt_q - ONE;
        end
      end
      S_STOP: begin
        if (rcnt_q == '0) begin
          rs_d    = S_IDLE;
          rx_done = rx_s2_q & ~rpar_q;
          rx_bad  = ~(rx_s2_q & ~rpar_q);
        end else begin
          rcnt_d = rcnt_q - ONE;
        end
      end
      default: rs_d = S_IDLE;
    endcase
  end

  state_e        ts_q, ts_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    tbit_q, tbit_d;
  logic [7:0]    tsh_q, tsh_d;
  logic          tx_q, tx_d;

  assign tx_busy = (ts_q != S_IDLE);

  // tx_d is the line level for the state being entered
  always_comb begin
    ts_d   = ts_q;
    tcnt_d = tcnt_q;
    tbit_d = tbit_q;
    tsh_d  = tsh_q;
    tx_d   = tx_q;
    unique case (ts_q)
      S_IDLE: begin
        if (we_txd) begin
          tsh_d  = wdata[7:0];
          ts_d   = S_START;
          tcnt_d = BIT_MAX;
          tx_d   = 1'b0;
        end
      end
      S_START: begin
        if (tcnt_q == '0) begin
          ts_d   = S_DATA;
          tcnt_d = BIT_MAX;
          tbit_d = 3'd0;
          tx_d   = tsh_q[0];
        end else begin
          tcnt_d = tcnt_q - ONE;
        end
      end
      S_DATA: begin
        if (tcnt_q == '0) begin
          tcnt_d = BIT_MAX;
          if (tbit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            ts_d = S_PAR;
            tx_d = ^tsh_q;
`else
            ts_d = S_STOP;
            tx_d = 1'b1;
`endif
          end else begin
            tbit_d = tbit_q + 3'd1;
            tx_d   = tsh_q[tbit_q + 3'd1];
          end
        end else begin
          tcnt_d = tcnt_q - ONE;
        end
      end
      S_PAR: begin
        if (tcnt_q == '0) begin
          ts_d   = S_STOP;
          tcnt_d = BIT_MAX;
          tx_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q - ONE;
        end
      end
      S_STOP: begin
        if (tcnt_q == '0) begin
          ts_d = S_IDLE;
          tx_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q - ONE;
        end
      end
      default: ts_d = S_IDLE;
    endcase
  end

  // Software writes first so hardware sets win on the same edge
  always_comb begin
    op1_d   = op1_q;
    op2_d   = op2_q;
    ready_d = ready_q;
    irqen_d = irqen_q;
    err_d   = err_q;
    ptr_d   = ptr_q;
    if (we_con) begin
      irqen_d = wdata[1];
      if (!wdata[0]) ready_d = 1'b0;
      if (!wdata[3]) err_d = 1'b0;
    end
    if (rx_bad) err_d = 1'b1;
    if (rx_done) begin
      if (ready_q) begin
        err_d = 1'b1;
      end else if (!ptr_q) begin
        op1_d = rsh_q;
        ptr_d = 1'b1;
      end else begin
        op2_d   = rsh_q;
        ptr_d   = 1'b0;
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_q    <= S_IDLE;
      rcnt_q  <= '0;
      rbit_q  <= '0;
      rsh_q   <= '0;
      rpar_q  <= 1'b0;
      ts_q    <= S_IDLE;
      tcnt_q  <= '0;
      tbit_q  <= '0;
      tsh_q   <= '0;
      tx_q    <= 1'b1;
      op1_q   <= '0;
      op2_q   <= '0;
      ready_q <= 1'b0;
      irqen_q <= 1'b0;
      err_q   <= 1'b0;
      ptr_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      rs_q    <= rs_d;
      rcnt_q  <= rcnt_d;
      rbit_q  <= rbit_d;
      rsh_q   <= rsh_d;
      rpar_q  <= rpar_d;
      ts_q    <= ts_d;
      tcnt_q  <= tcnt_d;
      tbit_q  <= tbit_d;
      tsh_q   <= tsh_d;
      tx_q    <= tx_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      ready_q <= ready_d;
      irqen_q <= irqen_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      irq_q   <= ready_q & irqen_q;
    end
  end

  assign tx  = tx_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_uart_bus_responder.sv
// Directed bench for uart_bus_responder at CLKS_PER_BIT=4.
// Expectations follow UART_PARITY_EN when it is defined.
`timescale 1ns/1ps
module tb_uart_bus_responder;

  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam logic [31:0] A_OP1 = 32'h4000_0018;
  localparam logic [31:0] A_OP2 = 32'h4000_001C;
  localparam logic [31:0] A_TXD = 32'h4000_0020;
  localparam logic [31:0] A_CON = 32'h4000_0024;

  logic        clk, reset;
  logic [31:0] addr, wdata, rdata;
  logic        mem_read, mem_write;
  logic        rx, tx, irq;

  uart_bus_responder #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR   (32'h4000_0018)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .wdata    (wdata),
    .rdata    (rdata),
    .rx       (rx),
    .tx       (tx),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic bus_rd(input logic [31:0] a,
                        output logic [31:0] d);
    @(negedge clk);
    addr = a;
    mem_read = 1'b1;
    #1 d = rdata;
    mem_read = 1'b0;
    addr = '0;
  endtask

  task automatic chk_rd(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic bus_wr(input logic [31:0] a,
                        input logic [31:0] d);
    @(negedge clk);
    addr = a;
    wdata = d;
    mem_write = 1'b1;
    @(posedge clk);
    #1 mem_write = 1'b0;
    addr = '0;
    wdata = '0;
  endtask

  task automatic rx_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic stopb);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
`ifdef UART_PARITY_EN
    rx_bit(^b);
`endif
    rx_bit(stopb);
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
  endtask

`ifdef UART_PARITY_EN
  task automatic send_bad_par(input logic [7:0] b);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(~(^b));
    rx_bit(1'b1);
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
  endtask
`endif

  // Writes b to TXD, injects a second TXD write mid-frame, and
  // samples tx plus CON.TX_BUSY once per cycle.
  task automatic tx_frame(input logic [7:0] b);
    logic [NBITS-1:0] eb;
    logic             samp [0:NBITS*CPB+7];
    logic [3:0]       v;
    logic [7:0]       idle;
    int               busy_n;
    busy_n = 0;
    eb[0] = 1'b0;
    for (int i = 0; i < 8; i++) eb[i+1] = b[i];
`ifdef UART_PARITY_EN
    eb[9] = ^b;
`endif
    eb[NBITS-1] = 1'b1;
    bus_wr(A_TXD, {24'b0, b});
    for (int c = 0; c < NBITS*CPB+8; c++) begin
      @(negedge clk);
      addr = A_CON;
      mem_read = 1'b1;
      #1;
      busy_n += int'(rdata[2]);
      samp[c] = tx;
      mem_read = 1'b0;
      if (c == 10) begin
        addr = A_TXD;
        wdata = 32'hFF;
        mem_write = 1'b1;
        @(posedge clk);
        #1 mem_write = 1'b0;
        wdata = '0;
      end
      addr = '0;
    end
    chk($sformatf("busy_cycles_%h", b), busy_n, NBITS*CPB);
    for (int k = 0; k < NBITS; k++) begin
      v = {samp[4*k+3], samp[4*k+2],
           samp[4*k+1], samp[4*k]};
      chk($sformatf("tx_%h_bit%0d", b, k), {28'b0, v},
          {28'b0, {4{eb[k]}}});
    end
    for (int k = 0; k < 8; k++) idle[k] = samp[NBITS*CPB+k];
    chk($sformatf("tx_%h_idle", b), {24'b0, idle}, 32'hFF);
  endtask

  initial begin
    logic seen, irq0, irq1;
    reset = 1'b1;
    rx = 1'b1;
    addr = '0;
    wdata = '0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk_rd("rst_con", A_CON, 32'h0);
    chk_rd("rst_op1", A_OP1, 32'h0);
    chk_rd("rst_op2", A_OP2, 32'h0);
    chk_rd("unmapped_lo", 32'h4000_0000, 32'h0);
    chk_rd("unmapped_hi", 32'h4000_0028, 32'h0);
    chk("rst_tx", {31'b0, tx}, 32'h1);
    chk("rst_irq", {31'b0, irq}, 32'h0);

    bus_wr(A_CON, 32'h2);
    chk_rd("con_irqen", A_CON, 32'h2);

    send_byte(8'h24, 1'b1);
    chk_rd("op1_first", A_OP1, 32'h24);
    chk_rd("con_one_byte", A_CON, 32'h2);

    seen = 1'b0;
    irq0 = 1'b1;
    irq1 = 1'b0;
    fork
      send_byte(8'h3C, 1'b1);
      begin
        for (int c = 0; c < 80 && !seen; c++) begin
          @(negedge clk);
          addr = A_CON;
          mem_read = 1'b1;
          #1;
          if (rdata[0]) begin
            seen = 1'b1;
            irq0 = irq;
            @(negedge clk);
            irq1 = irq;
          end
          mem_read = 1'b0;
          addr = '0;
        end
      end
    join
    chk("ready_seen", {31'b0, seen}, 32'h1);
    chk("irq_same_cycle", {31'b0, irq0}, 32'h0);
    chk("irq_next_cycle", {31'b0, irq1}, 32'h1);
    chk_rd("op1_pair", A_OP1, 32'h24);
    chk_rd("op2_pair", A_OP2, 32'h3C);
    chk_rd("con_ready", A_CON, 32'h3);

    send_byte(8'h55, 1'b1);
    chk_rd("op1_overrun", A_OP1, 32'h24);
    chk_rd("op2_overrun", A_OP2, 32'h3C);
    chk_rd("con_overrun", A_CON, 32'hB);

    bus_wr(A_CON, 32'h2);
    chk_rd("con_cleared", A_CON, 32'h2);
    repeat (2) @(negedge clk);
    chk("irq_cleared", {31'b0, irq}, 32'h0);

    @(posedge clk);
    #1 rx = 1'b0;
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (20) @(posedge clk);
    chk_rd("con_glitch", A_CON, 32'h2);

    send_byte(8'h12, 1'b0);
    chk_rd("con_frame_err", A_CON, 32'hA);
    chk_rd("op1_frame_err", A_OP1, 32'h24);

    send_byte(8'h66, 1'b1);
    chk_rd("op1_ptr_kept", A_OP1, 32'h66);
    chk_rd("con_ptr_kept", A_CON, 32'hA);
    bus_wr(A_CON, 32'h2);
    chk_rd("con_err_clr", A_CON, 32'h2);

    tx_frame(8'hA5);
    chk_rd("txd_reads_0", A_TXD, 32'h0);
`ifdef UART_PARITY_EN
    tx_frame(8'h07);
`endif

    bus_wr(A_TXD, 32'h00);
    rx = 1'b0;
    repeat (18) @(posedge clk);
    @(negedge clk);
    chk("tx_pre_reset", {31'b0, tx}, 32'h0);
    #1 reset = 1'b1;
    #1 chk("tx_on_reset", {31'b0, tx}, 32'h1);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_rd("post_rst_con", A_CON, 32'h0);
    chk_rd("post_rst_op1", A_OP1, 32'h0);
    chk_rd("post_rst_op2", A_OP2, 32'h0);
    chk("post_rst_tx", {31'b0, tx}, 32'h1);
    chk("post_rst_irq", {31'b0, irq}, 32'h0);

    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    chk_rd("op1_after_rst", A_OP1, 32'h5A);
    chk_rd("op2_after_rst", A_OP2, 32'hC3);
    chk_rd("con_after_rst", A_CON, 32'h1);
    chk("irq_masked", {31'b0, irq}, 32'h0);

`ifdef UART_PARITY_EN
    bus_wr(A_CON, 32'h0);
    send_bad_par(8'h07);
    chk_rd("con_par_err", A_CON, 32'h8);
    chk_rd("op1_par_err", A_OP1, 32'h5A);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
